// File: rtl/coffee_recipe_sequencer_if.sv
// Front-panel / valve-driver bundle for coffee_recipe_sequencer.
// The pause input exists only when PAUSE_DISPENSE_EN is defined.
interface coffee_recipe_sequencer_if #(
   parameter int NUM_ING = 5,
   parameter int TIME_W  = 2
);
   logic               start;
   logic [2:0]         coffee_type;
   logic               abort;
   logic               cfg_we;
   logic [2:0]         cfg_recipe;
   logic [2:0]         cfg_ing;
   logic [TIME_W-1:0]  cfg_time;
`ifdef PAUSE_DISPENSE_EN
   logic               pause;
`endif
   logic               busy;
   logic               done;
   logic               err;
   logic [NUM_ING-1:0] valve;
   logic [2:0]         ingredient_idx;

   modport master (
      output start, coffee_type, abort, cfg_we, cfg_recipe, cfg_ing, cfg_time,
`ifdef PAUSE_DISPENSE_EN
      output pause,
`endif
      input  busy, done, err, valve, ingredient_idx
   );

   modport slave (
      input  start, coffee_type, abort, cfg_we, cfg_recipe, cfg_ing, cfg_time,
`ifdef PAUSE_DISPENSE_EN
      input  pause,
`endif
      output busy, done, err, valve, ingredient_idx
   );
endinterface

// File: rtl/coffee_recipe_sequencer.sv
// Timed ingredient-dispense sequencer driven by a runtime-writable recipe table.
// Optional PAUSE_DISPENSE_EN adds a pause input that freezes the current dispense.
module coffee_recipe_sequencer #(
   parameter int NUM_ING     = 5,
   parameter int NUM_RECIPES = 4,
   parameter int TIME_W      = 2,
   parameter int TICK_DIV    = 50000000
) (
   input logic                   clk,
   input logic                   rst,
   coffee_recipe_sequencer_if.slave bus
);

   localparam longint unsigned MAX_CYC = longint'((2 ** TIME_W) - 1) * longint'(TICK_DIV);
   localparam int              CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] TICK     = CNT_W'(TICK_DIV);
   localparam logic [2:0]       LAST_ING = 3'(NUM_ING - 1);
   localparam logic [2:0]       MAX_REC  = 3'(NUM_RECIPES);
   localparam logic [NUM_ING-1:0] VALVE_ONE = NUM_ING'(1);

   typedef enum logic [1:0] {S_IDLE, S_SELECT, S_DISPENSE, S_DONE} state_t;
   typedef logic [TIME_W-1:0] entry_t;

   // Factory recipes, indexed by 1-based recipe number and ingredient.
   function automatic entry_t reset_entry(input logic [2:0] r, input logic [2:0] i);
      logic [2:0] v;
      case ({r, i})
         6'o10: v = 3'd2;  6'o11: v = 3'd3;  6'o14: v = 3'd1;
         6'o20: v = 3'd2;  6'o21: v = 3'd2;  6'o22: v = 3'd1;  6'o24: v = 3'd1;
         6'o30: v = 3'd2;  6'o31: v = 3'd1;  6'o32: v = 3'd2;  6'o34: v = 3'd1;
         6'o40: v = 3'd1;  6'o41: v = 3'd1;  6'o42: v = 3'd1;  6'o43: v = 3'd2;
         6'o44: v = 3'd1;
         default: v = 3'd0;
      endcase
      if (r == 3'd0 || r > MAX_REC || i > LAST_ING) v = 3'd0;
      return entry_t'(v);
   endfunction

   state_t           state, state_d;
   logic [2:0]       idx, idx_d;
   logic [2:0]       rtype, rtype_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             err_q, err_d;
   logic             wr_en;
   logic             hold;
   entry_t           entry;
   entry_t           tbl [8][8];

`ifdef PAUSE_DISPENSE_EN
   assign hold = bus.pause;
`else
   assign hold = 1'b0;
`endif

   // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         idx   <= '0;
         rtype <= '0;
         cnt   <= '0;
         err_q <= 1'b0;
         // NOTE: the table is reset flop by flop because rst must restore the factory recipes.
         for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++)
               tbl[r[2:0]][i[2:0]] <= reset_entry(r[2:0], i[2:0]);
      end else begin
         state <= state_d;
         idx   <= idx_d;
         rtype <= rtype_d;
         cnt   <= cnt_d;
         err_q <= err_d;
         if (wr_en) tbl[bus.cfg_recipe][bus.cfg_ing] <= bus.cfg_time;
      end
   end

   // NOTE: every signal driven here gets a default first, so no latch can be inferred.
   always_comb begin
      state_d = state;
      idx_d   = idx;
      rtype_d = rtype;
      cnt_d   = cnt;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      entry   = tbl[rtype][idx];

      bus.busy           = (state != S_IDLE);
      bus.done           = 1'b0;
      bus.err            = err_q;
      bus.valve          = '0;
      bus.ingredient_idx = idx;

      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.coffee_type != 3'd0 && bus.coffee_type <= MAX_REC) begin
                  rtype_d = bus.coffee_type;
                  idx_d   = '0;
                  state_d = S_SELECT;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_SELECT: begin
            if (entry == '0) begin
               if (idx == LAST_ING) state_d = S_DONE;
               else                 idx_d   = idx + 3'd1;
            end else begin
               cnt_d   = CNT_W'(entry) * TICK - CNT_W'(1);
               state_d = S_DISPENSE;
            end
         end
         S_DISPENSE: begin
            // A paused dispense keeps its remaining count, so total open time is preserved.
            if (!hold) begin
               bus.valve = VALVE_ONE << idx;
               if (cnt == '0) begin
                  if (idx == LAST_ING) state_d = S_DONE;
                  else begin
                     idx_d   = idx + 3'd1;
                     state_d = S_SELECT;
                  end
               end else begin
                  cnt_d = cnt - CNT_W'(1);
               end
            end
         end
         S_DONE: begin
            bus.done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Table writes are only legal while idle; a same-cycle start sees the new value in SELECT.
      if (bus.cfg_we) begin
         if (state == S_IDLE && bus.cfg_recipe != 3'd0 && bus.cfg_recipe <= MAX_REC &&
             bus.cfg_ing <= LAST_ING)
            wr_en = 1'b1;
         else
            err_d = 1'b1;
      end

      if (bus.abort && state != S_IDLE) state_d = S_IDLE;
   end

endmodule
